// File: rtl/ata_pkg.sv
// Shared ATA definitions: timing-word field slots, PIO FSM encoding and task-file addresses.
// Consumed by the PIO access controller and its timing-set selector.
package ata_pkg;

  // Field slot within a packed timing word, LSB-first; bit offset = slot * TWIDTH
  localparam int TF_T1   = 0;
  localparam int TF_T2   = 1;
  localparam int TF_T4   = 2;
  localparam int TF_TEOC = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } pio_state_t;

  // {CS1 select, DA[2:0]}
  localparam logic [3:0] ATA_DATA    = {1'b0, 3'd0};
  localparam logic [3:0] ATA_DEVHEAD = {1'b0, 3'd6};

endpackage

// File: rtl/pio_tsel.sv
// Picks the timing set for an access (per-device fast data-port timing or compatible timing)
// and unpacks it into its four fields; purely combinational.
module pio_tsel
  import ata_pkg::*;
#(
  parameter int TWIDTH = 8
) (
  input  logic [3:0]          req_a,
  input  logic                dev_sel,
  input  logic                fte_dev0,
  input  logic                fte_dev1,
  input  logic [4*TWIDTH-1:0] tim_cmpt,
  input  logic [4*TWIDTH-1:0] tim_dev0,
  input  logic [4*TWIDTH-1:0] tim_dev1,
  output logic [TWIDTH-1:0]   t1,
  output logic [TWIDTH-1:0]   t2,
  output logic [TWIDTH-1:0]   t4,
  output logic [TWIDTH-1:0]   teoc
);

  logic [4*TWIDTH-1:0] tim;
  logic                fte;

  always_comb begin
    fte = dev_sel ? fte_dev1 : fte_dev0;
    tim = tim_cmpt;
    // Fast timing only ever applies to the data port of the selected device
    if ((req_a == ATA_DATA) && fte) begin
      tim = dev_sel ? tim_dev1 : tim_dev0;
    end
  end

  assign t1   = tim[TF_T1*TWIDTH   +: TWIDTH];
  assign t2   = tim[TF_T2*TWIDTH   +: TWIDTH];
  assign t4   = tim[TF_T4*TWIDTH   +: TWIDTH];
  assign teoc = tim[TF_TEOC*TWIDTH +: TWIDTH];

endmodule

// File: rtl/pio_access_ctrl.sv
// PIO access sequencer: latches a host request, launches one timing-controller cycle,
// captures read data on dstrb and returns a single-cycle ack (minimum 4 cycles per access).
module pio_access_ctrl
  import ata_pkg::*;
#(
  parameter int TWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                req_we,
  input  logic [3:0]          req_a,
  input  logic [15:0]         req_d,
  output logic                ack,
  output logic [15:0]         rd_q,
  input  logic [4*TWIDTH-1:0] tim_cmpt,
  input  logic [4*TWIDTH-1:0] tim_dev0,
  input  logic [4*TWIDTH-1:0] tim_dev1,
  input  logic                fte_dev0,
  input  logic                fte_dev1,
  input  logic                IORDY_en,
  output logic                go,
  output logic                we,
  output logic [TWIDTH-1:0]   T1,
  output logic [TWIDTH-1:0]   T2,
  output logic [TWIDTH-1:0]   T4,
  output logic [TWIDTH-1:0]   Teoc,
  output logic                IORDY_en_o,
  input  logic                done,
  input  logic                dstrb,
  output logic [2:0]          DA,
  output logic                CS0,
  output logic                CS1,
  output logic [15:0]         dd_o,
  input  logic [15:0]         dd_i,
  output logic                dev_sel
);

  pio_state_t          state, state_nxt;
  logic                accept;
  logic                dstrb_seen;
  logic [TWIDTH-1:0]   tsel_t1, tsel_t2, tsel_t4, tsel_teoc;

  assign IORDY_en_o = IORDY_en;
  assign accept     = (state == ST_IDLE) && req;

  // Selection sees the pre-access dev_sel because dev_sel only moves after GO
  pio_tsel #(.TWIDTH(TWIDTH)) u_tsel (
    .req_a    (req_a),
    .dev_sel  (dev_sel),
    .fte_dev0 (fte_dev0),
    .fte_dev1 (fte_dev1),
    .tim_cmpt (tim_cmpt),
    .tim_dev0 (tim_dev0),
    .tim_dev1 (tim_dev1),
    .t1       (tsel_t1),
    .t2       (tsel_t2),
    .t4       (tsel_t4),
    .teoc     (tsel_teoc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    ack       = 1'b0;
    unique case (state)
      ST_IDLE: if (req) state_nxt = ST_GO;
      ST_GO: begin
        go        = !rst;
        state_nxt = ST_WAIT;
      end
      // A read may see dstrb before, with, or after done; only done+strobe completes it
      ST_WAIT: if (done && (we || dstrb_seen || dstrb)) state_nxt = ST_ACK;
      ST_ACK: begin
        ack       = !rst;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      DA         <= 3'd0;
      CS0        <= 1'b0;
      CS1        <= 1'b0;
      dd_o       <= 16'd0;
      T1         <= '0;
      T2         <= '0;
      T4         <= '0;
      Teoc       <= '0;
      dev_sel    <= 1'b0;
      dstrb_seen <= 1'b0;
      rd_q       <= 16'd0;
    end else begin
      if (accept) begin
        we   <= req_we;
        DA   <= req_a[2:0];
        CS0  <= !req_a[3];
        CS1  <= req_a[3];
        dd_o <= req_d;
        T1   <= tsel_t1;
        T2   <= tsel_t2;
        T4   <= tsel_t4;
        Teoc <= tsel_teoc;
      end
      if ((state == ST_GO) && we && ({CS1, DA} == ATA_DEVHEAD)) begin
        dev_sel <= dd_o[4];
      end
      if ((state != ST_IDLE) && !we && dstrb) begin
        dstrb_seen <= 1'b1;
        rd_q       <= dd_i;
      end
      if (state == ST_ACK) dstrb_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pio_access_ctrl.sv
// Self-checking bench for pio_access_ctrl; the bench plays host and timing controller.
module tb_pio_access_ctrl;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst, req, req_we;
  logic [3:0]      req_a;
  logic [15:0]     req_d;
  logic            ack;
  logic [15:0]     rd_q;
  logic [4*TW-1:0] tim_cmpt, tim_dev0, tim_dev1;
  logic            fte_dev0, fte_dev1, IORDY_en;
  logic            go, we;
  logic [TW-1:0]   T1, T2, T4, Teoc;
  logic            IORDY_en_o, done, dstrb;
  logic [2:0]      DA;
  logic            CS0, CS1;
  logic [15:0]     dd_o, dd_i;
  logic            dev_sel;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_dev_sel;
  logic [15:0] m_rd_q;

  always #5 clk = ~clk;

  pio_access_ctrl #(.TWIDTH(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_a(req_a), .req_d(req_d),
    .ack(ack), .rd_q(rd_q), .tim_cmpt(tim_cmpt), .tim_dev0(tim_dev0), .tim_dev1(tim_dev1),
    .fte_dev0(fte_dev0), .fte_dev1(fte_dev1), .IORDY_en(IORDY_en), .go(go), .we(we),
    .T1(T1), .T2(T2), .T4(T4), .Teoc(Teoc), .IORDY_en_o(IORDY_en_o), .done(done),
    .dstrb(dstrb), .DA(DA), .CS0(CS0), .CS1(CS1), .dd_o(dd_o), .dd_i(dd_i), .dev_sel(dev_sel)
  );

  // Timing set the model expects: fast set of the current device only for the data port
  function automatic logic [4*TW-1:0] exp_tim(input logic [3:0] a);
    logic [4*TW-1:0] dev_set [2];
    bit              fte [2];
    dev_set[0] = tim_dev0; dev_set[1] = tim_dev1;
    fte[0] = fte_dev0;     fte[1] = fte_dev1;
    if (a == 4'h0 && fte[m_dev_sel]) return dev_set[m_dev_sel];
    return tim_cmpt;
  endfunction

  task automatic issue_req(input logic w, input logic [3:0] a, input logic [15:0] d, output bit got);
    int lat;
    @(negedge clk);
    req = 1'b1; req_we = w; req_a = a; req_d = d;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (go) got = 1'b1;
    end
    // scramble request inputs: the DUT must already hold its copy
    req = 1'b0; req_we = 1'($urandom); req_a = 4'($urandom); req_d = 16'($urandom);
    checks++;
    if (!got || lat != 1) begin
      failures++;
      $display("FAIL go_latency got=%0d exp=1 (seen=%0d)", lat, got);
    end
  endtask

  task automatic run_access(input logic w, input logic [3:0] a, input logic [15:0] d,
                            input logic [15:0] rdata, input int stall);
    logic [4*TW-1:0] et;
    logic [21:0]     bus_exp;
    logic [15:0]     exp_rd;
    bit              got;
    int              bad;
    et      = exp_tim(a);
    bus_exp = {a[3], ~a[3], a[2:0], w, d};
    exp_rd  = w ? m_rd_q : rdata;
    issue_req(w, a, d, got);
    if (!got) return;
    checks++;
    if ({CS1, CS0, DA, we, dd_o} !== bus_exp) begin
      failures++;
      $display("FAIL bus_at_go got=%h exp=%h", {CS1, CS0, DA, we, dd_o}, bus_exp);
    end
    checks++;
    if ({Teoc, T4, T2, T1} !== et) begin
      failures++;
      $display("FAIL timing_at_go got=%h exp=%h", {Teoc, T4, T2, T1}, et);
    end
    @(negedge clk);
    checks++;
    if (go !== 1'b0) begin failures++; $display("FAIL go_width got=%b exp=0", go); end
    bad = 0;
    repeat (stall) begin
      done = 1'b0; dstrb = 1'b0;
      @(negedge clk);
      if (ack || go || {CS1, CS0, DA, we, dd_o} !== bus_exp || {Teoc, T4, T2, T1} !== et) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
    // completion: writes also see a strobe so rd_q must ignore it
    done = 1'b1; dstrb = 1'b1; dd_i = rdata;
    @(negedge clk);
    done = 1'b0; dstrb = 1'b0; dd_i = 16'hFFFF;
    checks++;
    if (ack !== 1'b1 || rd_q !== exp_rd) begin
      failures++;
      $display("FAIL ack_rdq got=%b/%h exp=1/%h", ack, rd_q, exp_rd);
    end
    @(negedge clk);
    if (w && a == 4'h6) m_dev_sel = d[4];
    m_rd_q = exp_rd;
    checks++;
    if (ack !== 1'b0 || rd_q !== m_rd_q || dev_sel !== m_dev_sel) begin
      failures++;
      $display("FAIL post_ack got=%b/%h/%b exp=0/%h/%b", ack, rd_q, dev_sel, m_rd_q, m_dev_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; req_we = 1'b1; req_a = 4'h6; req_d = 16'hFFFF;
    done = 1'b1; dstrb = 1'b1; dd_i = 16'h1234; IORDY_en = 1'b1;
    fte_dev0 = 1'b0; fte_dev1 = 1'b0;
    tim_cmpt = 32'h0A0B0C0D; tim_dev0 = 32'h11223344; tim_dev1 = 32'h55667788;
    repeat (3) @(negedge clk);
    checks++;
    if ({go, we, ack, CS0, CS1, dev_sel, DA, dd_o, rd_q, T1, T2, T4, Teoc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {go, we, ack, CS0, CS1, dev_sel, DA, dd_o, rd_q, T1, T2, T4, Teoc});
    end
    checks++;
    if (IORDY_en_o !== 1'b1) begin failures++; $display("FAIL iordy_rst got=%b exp=1", IORDY_en_o); end
    IORDY_en = 1'b0;
    @(negedge clk);
    req = 1'b0; rst = 1'b0; done = 1'b0; dstrb = 1'b0;
    m_dev_sel = 1'b0; m_rd_q = 16'h0;
    checks++;
    if (IORDY_en_o !== 1'b0) begin failures++; $display("FAIL iordy_pass got=%b exp=0", IORDY_en_o); end
  endtask

  task automatic test_idle_ignore();
    int bad = 0;
    repeat (4) begin
      @(negedge clk);
      done = 1'b1; dstrb = 1'b1; dd_i = 16'($urandom);
      if (ack || go || rd_q !== 16'h0 || CS0 || we) bad++;
    end
    @(negedge clk);
    done = 1'b0; dstrb = 1'b0;
    if (ack || go || rd_q !== 16'h0) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL idle_ignore bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_write();
    run_access(1'b1, 4'h6, 16'h0010, 16'h5A5A, 1);
    checks++;
    if (dev_sel !== 1'b1 || CS0 !== 1'b1 || DA !== 3'd6) begin
      failures++;
      $display("FAIL devhead_write got=%b/%b/%0d exp=1/1/6", dev_sel, CS0, DA);
    end
  endtask

  task automatic test_fast_timing();
    fte_dev0 = 1'b0; fte_dev1 = 1'b1;
    tim_dev1 = {8'd4, 8'd1, 8'd9, 8'd2};
    tim_cmpt = 32'h21_13_07_03;
    run_access(1'b0, 4'h0, 16'h0, 16'h1357, 0);
    checks++;
    if ({T1, T2, T4, Teoc} !== {8'd2, 8'd9, 8'd1, 8'd4}) begin
      failures++;
      $display("FAIL fast_timing got=%0d/%0d/%0d/%0d exp=2/9/1/4", T1, T2, T4, Teoc);
    end
    run_access(1'b0, 4'h7, 16'h0, 16'h2468, 0);
    checks++;
    if ({T1, T2, T4, Teoc} !== {8'd3, 8'd7, 8'd19, 8'd33}) begin
      failures++;
      $display("FAIL cmpt_timing got=%0d/%0d/%0d/%0d exp=3/7/19/33", T1, T2, T4, Teoc);
    end
  endtask

  task automatic test_read_capture();
    run_access(1'b0, 4'h0, 16'h0, 16'hA5C3, 2);
    checks++;
    if (rd_q !== 16'hA5C3) begin failures++; $display("FAIL read_capture got=%h exp=a5c3", rd_q); end
  endtask

  task automatic test_ordering();
    bit got;
    issue_req(1'b0, 4'h1, 16'h0, got);
    if (!got) return;
    @(negedge clk);
    done = 1'b1; dstrb = 1'b0; dd_i = 16'h0F0F;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL done_before_dstrb got=%b exp=0", ack); end
    dstrb = 1'b1; dd_i = 16'h3C69;
    @(negedge clk);
    done = 1'b0; dstrb = 1'b0; dd_i = 16'hFFFF;
    checks++;
    if (ack !== 1'b1 || rd_q !== 16'h3C69) begin
      failures++;
      $display("FAIL ack_after_dstrb got=%b/%h exp=1/3c69", ack, rd_q);
    end
    m_rd_q = 16'h3C69;
    @(negedge clk);
  endtask

  task automatic test_stall();
    run_access(1'b0, 4'h1, 16'h0, 16'h7E81, 50);
  endtask

  task automatic test_back_to_back();
    logic [15:0] data [3];
    logic [21:0] snap;
    int gos = 0, acks = 0, cyc = 0, last_go = 0, min_gap = 1000, unstable = 0;
    for (int i = 0; i < 3; i++) data[i] = 16'($urandom);
    snap = '0;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_a = 4'h2; req_d = data[0]; done = 1'b1;
    while (acks < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (go) begin
        if (gos > 0 && cyc - last_go < min_gap) min_gap = cyc - last_go;
        last_go = cyc;
        checks++;
        if (dd_o !== data[gos]) begin failures++; $display("FAIL b2b_data got=%h exp=%h", dd_o, data[gos]); end
        snap = {CS1, CS0, DA, we, dd_o};
        gos++;
        if (gos < 3) req_d = data[gos];
      end else if (gos > 0 && {CS1, CS0, DA, we, dd_o} !== snap) begin
        unstable++;
      end
      if (ack) begin
        acks++;
        if (acks == 3) req = 1'b0;
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (go) gos++;
      if (ack) acks++;
    end
    done = 1'b0;
    checks++;
    if (gos != 3 || acks != 3) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=3/3", gos, acks); end
    checks++;
    if (min_gap < 4 || unstable != 0) begin
      failures++;
      $display("FAIL b2b_spacing gap=%0d unstable=%0d exp>=4/0", min_gap, unstable);
    end
  endtask

  task automatic test_reset_in_wait();
    bit got;
    int bad = 0;
    issue_req(1'b0, 4'h3, 16'h0, got);
    if (!got) return;
    @(negedge clk);
    rst = 1'b1; done = 1'b1; dstrb = 1'b1; dd_i = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({go, we, ack, CS0, CS1, dev_sel, DA, dd_o, rd_q, T1, T2, T4, Teoc} !== '0) begin
      failures++;
      $display("FAIL rst_in_wait got=%h exp=0",
               {go, we, ack, CS0, CS1, dev_sel, DA, dd_o, rd_q, T1, T2, T4, Teoc});
    end
    rst = 1'b0;
    m_dev_sel = 1'b0; m_rd_q = 16'h0;
    repeat (3) begin
      @(negedge clk);
      if (ack || go) bad++;
    end
    done = 1'b0; dstrb = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_no_ack bad_cycles=%0d exp=0", bad); end
    run_access(1'b0, 4'h0, 16'h0, 16'hC001, 1);
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int i = 0; i < 30; i++) begin
      tim_cmpt = $urandom; tim_dev0 = $urandom; tim_dev1 = $urandom;
      fte_dev0 = 1'($urandom); fte_dev1 = 1'($urandom);
      case ($urandom_range(0, 2))
        0: a = 4'h0;
        1: a = 4'h6;
        default: a = 4'($urandom);
      endcase
      run_access(1'($urandom), a, 16'($urandom), 16'($urandom), $urandom_range(0, 4));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_reset_write();
    test_fast_timing();
    test_read_capture();
    test_ordering();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_access_ctrl.md
PIO_ACCESS_CTRL -- requirements
Module: pio_access_ctrl

Interface
REQ-001 SHALL have parameter TWIDTH, default 8, the width of each timing field in clk ticks.
REQ-002 SHALL have port clk, input, 1 bit: master clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req, req_we, req_a[3:0] and req_d[15:0] (all inputs): host request level, 1=write, address {CS1 select, DA[2:0]} and write data.
REQ-005 SHALL have ports ack (output, 1 bit, single-cycle completion) and rd_q (output, 16 bits, read data).
REQ-006 SHALL have ports tim_cmpt, tim_dev0 and tim_dev1 (inputs, 4*TWIDTH bits each), packed LSB-first as T1, T2, T4, Teoc.
REQ-007 SHALL have inputs fte_dev0 and fte_dev1 (1 bit each): fast data-port timing enable per device.
REQ-008 SHALL have input IORDY_en (1 bit), forwarded unchanged.
REQ-009 SHALL have timing-controller outputs go and we (1 bit each) and T1, T2, T4, Teoc (TWIDTH bits each), plus output IORDY_en_o (1 bit).
REQ-010 SHALL have timing-controller inputs done and dstrb (1 bit each).
REQ-011 SHALL have ATA-side outputs DA[2:0], CS0, CS1 (active high) and dd_o[15:0], input dd_i[15:0], and output dev_sel (1 bit, tracked DEV bit).

Function
REQ-012 SHALL implement FSM IDLE -> GO -> WAIT -> ACK -> IDLE.
REQ-013 In IDLE with req=1, SHALL latch req_we, req_a and req_d, select the timing set and enter GO on the next edge.
REQ-014 In IDLE, SHALL ignore req=0 and SHALL NOT change DA, CS0, CS1, dd_o, we or the timing outputs.
REQ-015 In GO, SHALL assert go for exactly one cycle, then enter WAIT.
REQ-016 SHALL decode addresses as CS0=!req_a[3] and CS1=req_a[3], with DA=req_a[2:0].
REQ-017 SHALL select timing tim_devN, where N=dev_sel, only when the access targets the data port (CS0, DA=0) and fte_devN=1; otherwise SHALL select tim_cmpt.
REQ-018 SHALL use the pre-access value of dev_sel for timing selection.
REQ-019 On acceptance of a write to CS0/DA=6 (device/head), SHALL update dev_sel to req_d[4] one cycle after acceptance.
REQ-020 SHALL hold DA, CS0, CS1, we, dd_o and the timing outputs stable from GO until the next acceptance.
REQ-021 In GO, WAIT or ACK, SHALL set a dstrb_seen flag when dstrb=1 on a read, and SHALL capture dd_i into rd_q on that same dstrb edge.
REQ-022 SHALL leave rd_q unchanged on writes.
REQ-023 In WAIT, SHALL enter ACK when done=1 and (we=1, or dstrb_seen=1, or dstrb=1); until then it SHALL stay in WAIT indefinitely, with no timeout.
REQ-024 In ACK, SHALL assert ack for exactly one cycle with rd_q valid, clear dstrb_seen, and return to IDLE.
REQ-025 SHALL accept a new request no earlier than the cycle after ACK, so req held continuously yields back-to-back accesses of at least 4 cycles each.
REQ-026 SHALL rely on the timing controller to stretch go until its end-of-cycle time.
REQ-027 SHALL ignore done or dstrb arriving in IDLE.

Reset
REQ-028 While rst=1, SHALL force the FSM to IDLE.
REQ-029 While rst=1, SHALL drive go, we, ack, CS0, CS1, dev_sel, dstrb_seen=0 and DA, dd_o, rd_q, T1, T2, T4, Teoc=0.
REQ-030 SHALL pass IORDY_en_o through unaffected by reset.
REQ-031 On rst asserted mid-access, SHALL abort with no ack; the timing controller is reset by the same rst.

Structure
REQ-032 SHALL take the following from the shared ata package: field offsets of the packed timing word, FSM state encoding, and address constants ATA_DATA={0,3'd0} and ATA_DEVHEAD={0,3'd6}.
REQ-033 SHALL place timing-set selection and unpacking in one combinational sub-module, pio_tsel, whose output is registered in pio_access_ctrl.

Verification
REQ-034 Bench SHALL cover a reset write: after rst, write req_a=4'h6, req_d=16'h0010 -> one go pulse, CS0=1, DA=6, ack once after done, dev_sel=1 afterwards.
REQ-035 Bench SHALL cover fast-timing selection: dev_sel=1, fte_dev1=1, tim_dev1={8'd4,8'd1,8'd9,8'd2}, read req_a=0 -> T1=2, T2=9, T4=1, Teoc=4; a read of req_a=4'h7 instead uses tim_cmpt.
REQ-036 Bench SHALL cover read capture: dd_i=16'hA5C3 at the dstrb cycle and 16'hFFFF afterwards -> rd_q=16'hA5C3 at ack.
REQ-037 Bench SHALL cover ordering and stalling: done asserted one cycle before dstrb on a read -> ack only after dstrb; done held low 50 cycles -> FSM stays in WAIT and ack=0.
REQ-038 Bench SHALL cover back-to-back accesses: req held high for 3 writes -> exactly 3 go pulses and 3 ack pulses, with outputs stable between go and the next acceptance.
REQ-039 Bench SHALL cover reset in WAIT: rst pulse -> no ack, all outputs zero, next request completes normally.
